// File: rtl/dac_spi_rx.sv
// dac_spi_rx: SPI mode-0 slave receiver for 16-bit DAC command frames.
// cs_n/sclk/mosi are synchronized into clk, edge-detected, and shifted MSB
// first. A frame of exactly 16 bits updates rx_data. When bit15==0 it also
// updates the decoded DAC fields. Any other bit count raises frame_err.
// Optional feature: define DAC_SPI_RX_ERRCNT_EN for a saturating 8-bit
// frame-error counter on err_count. Without it, err_count is tied to 0.
module dac_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic [11:0] dac_code,
  output logic        gain_n,
  output logic        shdn_n,
  output logic        dac_upd,
  output logic        frame_err,
  output logic        busy,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_prev_q, sclk_prev_q, mosi_prev_q;
  logic                   cs_fall_q, cs_rise_q, sclk_rise_q;
  logic [SYNC_STAGES:0]   init_q;
  logic                   arm_q;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic        frame_ok, frame_bad;

  logic [15:0] rx_data_q;
  logic        rx_valid_q, dac_upd_q, frame_err_q;
  logic [11:0] dac_code_q;
  logic        gain_n_q, shdn_n_q;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Pin synchronizers; cs_n idles high, sclk/mosi idle low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  // Registered edge detection. mosi is delayed alongside so it lines up
  // with sclk_rise_q. The arm flag blocks the false cs_n fall that would
  // appear when the pin is already low as reset releases: init_q waits
  // until the synchronizer holds real samples, then cs_n must be seen high
  // once before a fall is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      mosi_prev_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      init_q      <= '0;
      arm_q       <= 1'b0;
    end else begin
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      mosi_prev_q <= mosi_s;
      cs_fall_q   <= arm_q & cs_prev_q & ~cs_s;
      cs_rise_q   <= ~cs_prev_q & cs_s;
      sclk_rise_q <= ~sclk_prev_q & sclk_s;
      init_q      <= {init_q[SYNC_STAGES-1:0], 1'b1};
      arm_q       <= arm_q | (init_q[SYNC_STAGES] & cs_s);
    end
  end

  // FSM state, bit counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next state. The bit count saturates at 17 so any long frame stays != 16.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise_q) begin
          shreg_d = {shreg_q[14:0], mosi_prev_q};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
        if (cs_rise_q) state_d = DONE;
      end
      DONE: begin
        state_d   = IDLE;
        frame_ok  = (cnt_q == 5'd16);
        frame_bad = (cnt_q != 5'd16);
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame results. The decoded DAC fields load only for bit15==0 frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      dac_code_q  <= '0;
      gain_n_q    <= 1'b1;
      shdn_n_q    <= 1'b0;
      dac_upd_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= frame_ok;
      frame_err_q <= frame_bad;
      dac_upd_q   <= frame_ok & ~shreg_q[15];
      if (frame_ok) rx_data_q <= shreg_q;
      if (frame_ok && !shreg_q[15]) begin
        dac_code_q <= shreg_q[11:0];
        gain_n_q   <= shreg_q[13];
        shdn_n_q   <= shreg_q[12];
      end
    end
  end

`ifdef DAC_SPI_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating error counter. It steps on the same edge that raises frame_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                err_cnt_q <= '0;
    else if (frame_bad && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign dac_code  = dac_code_q;
  assign gain_n    = gain_n_q;
  assign shdn_n    = shdn_n_q;
  assign dac_upd   = dac_upd_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: a table of SPI frames feeds a scoreboard of expected
// frame results, plus hand sequences for latency, reset and loop-back.
module tb_dac_spi_rx;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid, gain_n, shdn_n, dac_upd, frame_err, busy;
  logic [11:0] dac_code;
  logic [7:0]  err_count;

  dac_spi_rx #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .rx_data(rx_data), .rx_valid(rx_valid), .dac_code(dac_code),
    .gain_n(gain_n), .shdn_n(shdn_n), .dac_upd(dac_upd),
    .frame_err(frame_err), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    int          half;
    int          gap;
    bit          exp_ok;
  } vec_t;

  typedef struct {
    bit          ok;
    logic [15:0] data;
    logic [11:0] dac;
    logic        gain_n;
    logic        shdn_n;
    logic        upd;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nbad = 0;

  // Reference model of the registered outputs.
  logic [15:0] m_rx;
  logic [11:0] m_dac;
  logic        m_gain, m_shdn;
  logic [7:0]  m_ecnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rx = '0; m_dac = '0; m_gain = 1'b1; m_shdn = 1'b0; m_ecnt = '0;
  endtask

  task automatic push_exp(input bit ok, input logic [31:0] d);
    exp_t e;
    e.ok = ok;
    e.upd = 1'b0;
    if (ok) begin
      m_rx = d[15:0];
      if (!d[15]) begin
        m_dac = d[11:0]; m_gain = d[13]; m_shdn = d[12]; e.upd = 1'b1;
      end
    end else begin
`ifdef DAC_SPI_RX_ERRCNT_EN
      if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
`endif
    end
    e.data = m_rx; e.dac = m_dac; e.gain_n = m_gain; e.shdn_n = m_shdn;
    e.ecnt = m_ecnt;
    sbq.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] d, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      wait_clk(half);
      sclk = 1'b1;
      wait_clk(half);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int n, input int half, input int gap);
    cs_n = 1'b0;
    wait_clk(half);
    shift_bits(d, n, half);
    wait_clk(half);
    cs_n = 1'b1;
    wait_clk(gap);
  endtask

  // Scoreboard: every rx_valid / frame_err / dac_upd pulse must match the
  // oldest expected frame result.
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err || dac_upd)) begin
      if (sbq.size() == 0) begin
        nvec++; nbad++;
        $display("FAIL unexpected_pulse rx_valid=%0b frame_err=%0b dac_upd=%0b", rx_valid, frame_err, dac_upd);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rx_valid",  {31'd0, rx_valid},  {31'd0, e.ok});
        check("frame_err", {31'd0, frame_err}, {31'd0, !e.ok});
        check("rx_data",   {16'd0, rx_data},   {16'd0, e.data});
        check("dac_code",  {20'd0, dac_code},  {20'd0, e.dac});
        check("gain_n",    {31'd0, gain_n},    {31'd0, e.gain_n});
        check("shdn_n",    {31'd0, shdn_n},    {31'd0, e.shdn_n});
        check("dac_upd",   {31'd0, dac_upd},   {31'd0, e.upd});
        check("err_count", {24'd0, err_count}, {24'd0, e.ecnt});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t        vt[10];
    logic        seen_busy;
    logic [31:0] w;

    vt[0] = '{32'h3ABC,  16, 5, 4, 1'b1};
    vt[1] = '{32'h9123,  16, 5, 4, 1'b1};
    vt[2] = '{32'hABC,   12, 5, 4, 1'b0};
    vt[3] = '{32'h2ABCD, 18, 5, 4, 1'b0};
    vt[4] = '{32'h0,      0, 5, 4, 1'b0};
    vt[5] = '{32'hC555,  16, 4, 3, 1'b1};
    vt[6] = '{32'h1000,  16, 3, 2, 1'b1};
    vt[7] = '{32'h1FFF,  16, 3, 2, 1'b1};
    vt[8] = '{32'h0000,  16, 3, 6, 1'b1};
    vt[9] = '{32'h7FFF,  16, 5, 6, 1'b1};

    model_reset();
    wait_clk(3);
    check("rst_rx_data",   {16'd0, rx_data},   32'h0);
    check("rst_rx_valid",  {31'd0, rx_valid},  32'h0);
    check("rst_dac_code",  {20'd0, dac_code},  32'h0);
    check("rst_gain_n",    {31'd0, gain_n},    32'h1);
    check("rst_shdn_n",    {31'd0, shdn_n},    32'h0);
    check("rst_busy",      {31'd0, busy},      32'h0);
    check("rst_err_count", {24'd0, err_count}, 32'h0);
    rst = 1'b0;
    wait_clk(8);

    for (int i = 0; i < 10; i++) begin
      push_exp(vt[i].exp_ok, vt[i].data);
      send_frame(vt[i].data, vt[i].nbits, vt[i].half, vt[i].gap);
    end
    wait_clk(10);

    // Latency from the first clk edge that samples cs_n high to rx_valid.
    push_exp(1'b1, 32'h0123);
    cs_n = 1'b0;
    wait_clk(5);
    shift_bits(32'h0123, 16, 5);
    wait_clk(5);
    cs_n = 1'b1;
    for (int k = 1; k <= S + 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d", k), {31'd0, rx_valid}, {31'd0, k == S + 3});
    end
    wait_clk(6);

    // Reset mid-frame with cs_n held low: the partial frame is dropped and
    // the block must stay idle until a fresh cs_n fall.
    cs_n = 1'b0;
    wait_clk(5);
    shift_bits(32'hA5, 8, 5);
    rst = 1'b1;
    model_reset();
    wait_clk(3);
    check("midrst_busy",    {31'd0, busy},    32'h0);
    check("midrst_rx_data", {16'd0, rx_data}, 32'h0);
    rst = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      repeat (4) begin
        @(negedge clk);
        if (busy) seen_busy = 1'b1;
      end
    end
    sclk = 1'b0;
    check("idle_after_rst_cs_low", {31'd0, seen_busy}, 32'h0);
    cs_n = 1'b1;
    wait_clk(4);
    push_exp(1'b1, 32'h1FFF);
    send_frame(32'h1FFF, 16, 5, 4);

    // Loop-back of sample words at the fastest legal sclk, mostly DAC writes.
    for (int i = 0; i < 64; i++) begin
      w = $urandom_range(0, 32'hFFFF);
      if (i % 8 != 7) w[15] = 1'b0;
      push_exp(1'b1, w);
      send_frame(w, 16, 3, 2);
    end

    for (int i = 0; i < 60 && sbq.size() != 0; i++) wait_clk(1);
    check("sb_drain", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/dac_spi_rx.md
DAC_SPI_RX -- requirements
Module: dac_spi_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on cs_n, sclk and mosi; legal values 2..3.
REQ-002 SHALL have port clk, input, 1, system clock (100 MHz PLL clock).
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port cs_n, input, 1, SPI chip select, active low, asynchronous to clk.
REQ-005 SHALL have port sclk, input, 1, SPI serial clock; mode 0, sampled on rising edge.
REQ-006 SHALL have port mosi, input, 1, SPI serial data, MSB first.
REQ-007 SHALL have port rx_data, output, 16, last complete frame.
REQ-008 SHALL have port rx_valid, output, 1, one-cycle pulse when a complete frame is received.
REQ-009 SHALL have port dac_code, output, 12, decoded DAC code, frame bits [11:0].
REQ-010 SHALL have port gain_n, output, 1, decoded gain select, frame bit 13.
REQ-011 SHALL have port shdn_n, output, 1, decoded shutdown, active low, frame bit 12.
REQ-012 SHALL have port dac_upd, output, 1, one-cycle pulse when the decoded outputs update.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse on a malformed frame.
REQ-014 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-015 SHALL have port err_count, output, 8, frame error count (see Configuration).

Function
REQ-016 SHALL synchronize cs_n, sclk and mosi through SYNC_STAGES flip-flops each; no other logic shall use the raw pins.
REQ-017 SHALL detect edges only on the synchronized signals; sclk high and low phases are each at least 3 clk cycles.
REQ-018 SHALL implement the FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE->SHIFT on a synchronized cs_n falling edge; bit counter and shift register are cleared.
- SHIFT: each sclk rising edge shifts mosi in at the LSB; the bit counter saturates at 17.
- SHIFT->DONE on a synchronized cs_n rising edge.
- DONE lasts exactly one cycle, then returns to IDLE.
REQ-019 In DONE with count==16, rx_data SHALL load the shift register and rx_valid SHALL pulse for 1 cycle.
REQ-020 In DONE with count!=16 (short, long or zero-bit frame), frame_err SHALL pulse for 1 cycle, and rx_data, dac_code, gain_n and shdn_n SHALL stay unchanged.
REQ-021 On a valid frame with bit15==0, dac_code, gain_n and shdn_n SHALL update in the same cycle as rx_valid, and dac_upd SHALL pulse.
REQ-022 On a valid frame with bit15==1, only rx_data SHALL update; dac_upd SHALL stay low; bit14 is ignored.
REQ-023 rx_valid SHALL assert exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples cs_n high at the pin.
REQ-024 sclk edges SHALL be ignored while in IDLE (cs_n high).
REQ-025 busy SHALL be high when state != IDLE.
REQ-026 A cs_n pulse of at least 2 clk cycles high between frames SHALL be sufficient; back-to-back frames SHALL be received without loss.

Reset
REQ-027 On rst, all of the following SHALL load asynchronously:
- state=IDLE; synchronizers=1 (cs_n), 0 (sclk, mosi);
- rx_data=0, rx_valid=0, dac_code=0, gain_n=1, shdn_n=0, dac_upd=0, frame_err=0, busy=0, err_count=0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no rx_valid and no frame_err.
REQ-029 If cs_n is low when reset deasserts, the block SHALL stay in IDLE until a fresh cs_n falling edge.

Configuration
REQ-030 With macro DAC_SPI_RX_ERRCNT_EN defined, err_count SHALL increment on each frame_err pulse and saturate at 255.
REQ-031 Without DAC_SPI_RX_ERRCNT_EN, err_count SHALL be tied to 0 and no counter logic shall be synthesized.

Verification
REQ-032 Frame 0x3ABC at an sclk of 10 clk/period -> rx_valid=1 for 1 cycle; rx_data=0x3ABC, dac_code=0xABC, gain_n=1, shdn_n=1, dac_upd pulses.
REQ-033 Frame 0x9123 -> rx_data=0x9123, rx_valid pulses, dac_upd stays 0, dac_code unchanged.
REQ-034 A 12-bit frame, then an 18-bit frame -> two frame_err pulses, no rx_valid, outputs unchanged; err_count=2 with the macro, 0 without.
REQ-035 rst pulse after 8 bits of a frame, cs_n held low -> no rx_valid and no frame_err for that frame; the next complete frame 0x1FFF is received correctly.
REQ-036 Two frames, 0x1000 then 0x1FFF, separated by 2 clk of cs_n high -> two rx_valid pulses with the correct data each.
REQ-037 Loop-back with the existing SPI transmitter FSM sending 1024 ROM samples -> each received dac_code equals the transmitted rom_data, with zero frame_err.
